// File: rtl/lif_tmux_scheduler.sv
// Time-multiplexed LIF engine: one shared leak/integrate/fire unit
// swept across N virtual neurons per accepted tick.
module lif_tmux_scheduler #(
   parameter int N          = 4,
   parameter int W          = 8,
   parameter int THRESH     = 128,
   parameter int LEAK_SHIFT = 1,
   parameter int REFRAC     = 2,
   localparam int IW        = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ena,
   input  logic           tick,
   input  logic [N*W-1:0] cur_in,
   input  logic           clr_overrun,
   output logic           busy,
   output logic           done,
   output logic [N-1:0]   spikes,
   output logic           slot_valid,
   output logic [IW-1:0]  slot_idx,
   output logic [W-1:0]   slot_state,
   output logic           slot_spike,
   output logic [N*W-1:0] state_flat,
   output logic           overrun
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_UPDATE,
      S_COMMIT
   } state_t;

   state_t         state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [W-1:0]   v_q [N];
   logic [W-1:0]   v_d [N];
   logic [W-1:0]   c_q [N];
   logic [W-1:0]   c_d [N];
   logic [3:0]     r_q [N];
   logic [3:0]     r_d [N];
   logic [N-1:0]   acc_q, acc_d;
   logic [N-1:0]   spikes_q, spikes_d;
   logic           done_q, done_d;
   logic           sv_q, sv_d;
   logic [IW-1:0]  sidx_q, sidx_d;
   logic [W-1:0]   sst_q, sst_d;
   logic           ssp_q, ssp_d;
   logic           ovr_q, ovr_d;

   logic [W-1:0]   v_cur, c_cur, leak, sat, new_v;
   logic [3:0]     r_cur, new_r;
   logic [W:0]     sum;
   logic           refr, fire;

   // Shared datapath for the neuron selected by idx_q
   always_comb begin
      v_cur = v_q[idx_q];
      c_cur = c_q[idx_q];
      r_cur = r_q[idx_q];
      refr  = (r_cur != 4'd0);
      leak  = v_cur - (v_cur >> LEAK_SHIFT);
      sum   = {1'b0, leak} + {1'b0, c_cur};
      sat   = sum[W] ? {W{1'b1}} : sum[W-1:0];
      fire  = !refr && (sat >= W'(THRESH));
      new_v = (refr || fire) ? '0 : sat;
      if (refr)
         new_r = r_cur - 4'd1;
      else if (fire)
         new_r = 4'(REFRAC);
      else
         new_r = 4'd0;
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      v_d      = v_q;
      c_d      = c_q;
      r_d      = r_q;
      acc_d    = acc_q;
      spikes_d = spikes_q;
      done_d   = 1'b0;
      sv_d     = 1'b0;
      sidx_d   = sidx_q;
      sst_d    = sst_q;
      ssp_d    = ssp_q;
      ovr_d    = ovr_q;
      if (clr_overrun)
         ovr_d = 1'b0;
      // A tick while busy is flagged but never queued
      if (tick && state_q != S_IDLE)
         ovr_d = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (tick && ena)
               state_d = S_LOAD;
         end
         S_LOAD: begin
            for (int i = 0; i < N; i++)
               c_d[i] = cur_in[i*W +: W];
            idx_d   = '0;
            acc_d   = '0;
            state_d = S_UPDATE;
         end
         S_UPDATE: begin
            v_d[idx_q]   = new_v;
            r_d[idx_q]   = new_r;
            acc_d[idx_q] = fire;
            sv_d         = 1'b1;
            sidx_d       = idx_q;
            sst_d        = new_v;
            ssp_d        = fire;
            if (idx_q == IW'(N-1)) begin
               spikes_d = acc_d;
               done_d   = 1'b1;
               state_d  = S_COMMIT;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_COMMIT: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         acc_q    <= '0;
         spikes_q <= '0;
         done_q   <= 1'b0;
         sv_q     <= 1'b0;
         sidx_q   <= '0;
         sst_q    <= '0;
         ssp_q    <= 1'b0;
         ovr_q    <= 1'b0;
         for (int i = 0; i < N; i++) begin
            v_q[i] <= '0;
            c_q[i] <= '0;
            r_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         acc_q    <= acc_d;
         spikes_q <= spikes_d;
         done_q   <= done_d;
         sv_q     <= sv_d;
         sidx_q   <= sidx_d;
         sst_q    <= sst_d;
         ssp_q    <= ssp_d;
         ovr_q    <= ovr_d;
         v_q      <= v_d;
         c_q      <= c_d;
         r_q      <= r_d;
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++)
         state_flat[i*W +: W] = v_q[i];
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign spikes     = spikes_q;
   assign slot_valid = sv_q;
   assign slot_idx   = sidx_q;
   assign slot_state = sst_q;
   assign slot_spike = ssp_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_lif_tmux_scheduler.sv
// Scoreboard bench for lif_tmux_scheduler: a default instance and a
// THRESH=255 instance share stimulus; each has its own reference model.
module tb_lif_tmux_scheduler;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int IW = 2;
   localparam int RF = 2;

   typedef struct {
      int idx;
      int st;
      int sp;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n, ena, tick, clr;
   logic [N*W-1:0] cur_in;

   logic           a_busy, a_done, a_sv, a_ssp, a_ovr;
   logic [N-1:0]   a_spk;
   logic [IW-1:0]  a_sidx;
   logic [W-1:0]   a_sst;
   logic [N*W-1:0] a_flat;
   logic           b_busy, b_done, b_sv, b_ssp, b_ovr;
   logic [N-1:0]   b_spk;
   logic [IW-1:0]  b_sidx;
   logic [W-1:0]   b_sst;
   logic [N*W-1:0] b_flat;

   exp_t qa[$];
   exp_t qb[$];
   int   mv [2][N];
   int   mr [2][N];
   int   nchk = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   lif_tmux_scheduler u_a (
      .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick),
      .cur_in(cur_in), .clr_overrun(clr),
      .busy(a_busy), .done(a_done), .spikes(a_spk),
      .slot_valid(a_sv), .slot_idx(a_sidx), .slot_state(a_sst),
      .slot_spike(a_ssp), .state_flat(a_flat), .overrun(a_ovr)
   );

   lif_tmux_scheduler #(.THRESH(255)) u_b (
      .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick),
      .cur_in(cur_in), .clr_overrun(clr),
      .busy(b_busy), .done(b_done), .spikes(b_spk),
      .slot_valid(b_sv), .slot_idx(b_sidx), .slot_state(b_sst),
      .slot_spike(b_ssp), .state_flat(b_flat), .overrun(b_ovr)
   );

   task automatic chk(input string tag, input int got, input int exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && a_sv) begin
         if (qa.size() == 0) begin
            chk("a_unexpected_slot", 1, 0);
         end else begin
            e = qa.pop_front();
            chk("a_slot_idx", int'(a_sidx), e.idx);
            chk("a_slot_state", int'(a_sst), e.st);
            chk("a_slot_spike", int'(a_ssp), e.sp);
            chk("a_flat", int'(a_flat[e.idx*W +: W]), e.st);
         end
      end
      if (rst_n && b_sv) begin
         if (qb.size() == 0) begin
            chk("b_unexpected_slot", 1, 0);
         end else begin
            e = qb.pop_front();
            chk("b_slot_idx", int'(b_sidx), e.idx);
            chk("b_slot_state", int'(b_sst), e.st);
            chk("b_slot_spike", int'(b_ssp), e.sp);
            chk("b_flat", int'(b_flat[e.idx*W +: W]), e.st);
         end
      end
   end

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < N; i++) begin
            mv[d][i] = 0;
            mr[d][i] = 0;
         end
   endtask

   task automatic model_sweep(input logic [N*W-1:0] cur,
                              output int esa, output int esb);
      int   th, s, sp, es;
      exp_t e;
      esa = 0;
      esb = 0;
      for (int d = 0; d < 2; d++) begin
         th = (d == 0) ? 128 : 255;
         es = 0;
         for (int i = 0; i < N; i++) begin
            sp = 0;
            if (mr[d][i] > 0) begin
               mv[d][i] = 0;
               mr[d][i]--;
            end else begin
               s = mv[d][i] - (mv[d][i] >> 1) + int'(cur[i*W +: W]);
               if (s > 255) s = 255;
               if (s >= th) begin
                  sp = 1;
                  mv[d][i] = 0;
                  mr[d][i] = RF;
               end else begin
                  mv[d][i] = s;
               end
            end
            es |= sp << i;
            e.idx = i;
            e.st  = mv[d][i];
            e.sp  = sp;
            if (d == 0) qa.push_back(e);
            else        qb.push_back(e);
         end
         if (d == 0) esa = es;
         else        esb = es;
      end
   endtask

   // otick raises tick again mid-sweep to exercise the overrun path
   task automatic sweep(input logic [N*W-1:0] cur, input bit otick);
      int esa, esb, k;
      model_sweep(cur, esa, esb);
      @(negedge clk);
      cur_in = cur;
      tick   = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      chk("busy_after_accept", int'(a_busy), 1);
      k = 0;
      while (k < 20) begin
         @(negedge clk);
         k++;
         if (k == 1) cur_in = {N{8'hC3}};
         if (otick && k == 3) tick = 1'b1;
         if (k == 4) tick = 1'b0;
         if (a_done) break;
      end
      chk("done_edge", k, N + 1);
      chk("b_done_edge", int'(b_done), 1);
      chk("a_spikes", int'(a_spk), esa);
      chk("b_spikes", int'(b_spk), esb);
      @(negedge clk);
      chk("done_pulse_low", int'(a_done), 0);
      chk("idle_after_n2", int'(a_busy), 0);
      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);
   endtask

   initial begin
      int k;
      logic [N*W-1:0] cur;
      rst_n  = 1'b0;
      ena    = 1'b1;
      tick   = 1'b0;
      clr    = 1'b0;
      cur_in = '0;
      model_reset();
      @(negedge clk);
      chk("rst_busy", int'(a_busy), 0);
      chk("rst_spikes", int'(a_spk), 0);
      chk("rst_flat", int'(a_flat), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_busy", int'(a_busy), 0);
         chk("idle_done", int'(a_done), 0);
         chk("idle_slot", int'(a_sv), 0);
         chk("idle_ovr", int'(a_ovr), 0);
      end

      // baseline, then fire and refractory on neuron 0
      cur = '0;
      cur[0 +: W] = 8'd100;
      for (int s = 0; s < 5; s++)
         sweep(cur, 1'b0);

      // saturation on neuron 1 (THRESH=255 instance)
      cur = '0;
      cur[W +: W] = 8'd200;
      sweep(cur, 1'b0);
      sweep(cur, 1'b0);

      // mixed pattern
      cur = {8'd40, 8'd90, 8'd7, 8'd130};
      sweep(cur, 1'b0);

      // overrun during UPDATE; only one sweep runs
      cur = {8'd10, 8'd20, 8'd30, 8'd40};
      sweep(cur, 1'b1);
      chk("overrun_set", int'(a_ovr), 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_second_sweep", int'(a_busy), 0);
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("overrun_clr", int'(a_ovr), 0);

      // ena gating
      ena  = 1'b0;
      tick = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("gated_busy", int'(a_busy), 0);
         chk("gated_ovr", int'(a_ovr), 0);
      end
      tick = 1'b0;
      ena  = 1'b1;

      // reset mid-sweep at idx 2
      cur = {8'd50, 8'd60, 8'd70, 8'd80};
      begin
         int esa, esb;
         model_sweep(cur, esa, esb);
      end
      @(negedge clk);
      cur_in = cur;
      tick   = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      k = 0;
      while (k < 20 && !(a_sv && a_sidx == IW'(2))) begin
         @(negedge clk);
         k++;
      end
      chk("reach_idx2", int'(k < 20), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", int'(a_busy), 0);
      chk("mid_rst_flat", int'(a_flat), 0);
      chk("mid_rst_spikes", int'(a_spk), 0);
      chk("mid_rst_slot", int'(a_sv), 0);
      chk("mid_rst_b_flat", int'(b_flat), 0);
      qa.delete();
      qb.delete();
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_rst_no_done", int'(a_done), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", int'(a_busy), 0);
      sweep(cur, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
